uart_mem_responder: RTL and testbench
=====================================

# uart_mem_responder

UART-attached data-memory responder: the far end of the CPU memory link that `memory_com` drives. It receives read/write request frames on `rx`, executes them against an internal word memory, and returns the read data or an acknowledge on `tx`. It sits on the FPGA/bench side opposite the CPU, so the complete datapath and memory link can run in hardware or simulation without a host PC.

## Interface
- `CLKS_PER_BIT`, 868, clock cycles per UART bit (8N1); must be ≥ 8.
- `DEPTH_LOG2`, 10, memory holds 2^DEPTH_LOG2 32-bit words.
- `TIMEOUT_CYCLES`, 20000, inter-byte abort limit (used only with MEM_RESP_TIMEOUT_EN).
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-low reset.
- `rx` in 1: serial request input; idle high; asynchronous to `clk`.
- `tx` out 1: serial response output; idle high.
- `busy` out 1: high from the first command byte until the last response stop bit completes.
- `frame_err` out 1: one-cycle pulse on a bad stop bit, unknown command, or timeout.
- `req_count` out 16: count of completed requests; wraps at 0xFFFF → 0.

## Operation
- Frame format, all bytes LSB first:
  - Write: `0x57`, addr[7:0], addr[15:8], addr[23:16], addr[31:24], data bytes 0–3.
  - Read: `0x52`, then 4 address bytes.
- Response:
  - Write: one byte `0x41`.
  - Read: 4 data bytes, LSB first.
  - Unknown command byte: one byte `0x4E`, plus a `frame_err` pulse.
- Word index is addr[DEPTH_LOG2+1:2]. Upper bits and addr[1:0] are ignored, so addresses wrap modulo the depth.
- RX path:
  - 2-flop synchronizer on `rx`.
  - Start bit is detected on a falling edge and confirmed at half a bit.
  - Data bits are sampled at mid-bit.
  - Stop bit is sampled at mid-bit. If it is 0, the byte is discarded, `frame_err` pulses, and the FSM returns to IDLE.
- FSM states: IDLE → CMD_DECODE → GET_ADDR (4 bytes) → GET_DATA (4 bytes, write only) → MEM_ACCESS (1 cycle) → SEND (1 or 4 bytes) → IDLE.
  - Unknown command: CMD_DECODE → SEND (NAK).
- Half-duplex: bytes that complete while in MEM_ACCESS or SEND are dropped silently.
- `req_count` increments on entry to SEND for valid read and write frames only.
- Reset values: `tx`=1, `busy`=0, `frame_err`=0, `req_count`=0, FSM=IDLE, all shift registers 0. Memory contents are not reset.
- Reset mid-frame or mid-send: `tx` returns high immediately and the partial frame is lost.

## Timing
- UART bit time is exactly CLKS_PER_BIT cycles. A byte is 10 bit times.
- Byte-complete strobe fires at the mid-point of the stop bit.
- MEM_ACCESS: the write is committed, or the read word is latched, in the cycle after the last request byte's strobe.
- The first response start bit (`tx` falling) occurs 2 cycles after that strobe.
- Multi-byte responses are back-to-back: the next start bit immediately follows the previous stop bit, with no idle gap.
- `busy` rises in the cycle after the command byte's strobe. It falls in the cycle after the final stop bit ends.
- A new frame is accepted once `busy`=0. A start bit already in progress when `busy` falls is still received.

## Configuration
- `MEM_RESP_TIMEOUT_EN` defined:
  - A counter runs in GET_ADDR and GET_DATA and clears on each byte strobe.
  - When it reaches TIMEOUT_CYCLES, the FSM returns to IDLE, `frame_err` pulses, and no response is sent.
- Not defined: no counter is built, and a partial frame waits indefinitely.

## Structure
- Shared package `mem_link_pkg` holds:
  - Command/response constants: CMD_WRITE=8'h57, CMD_READ=8'h52, RSP_ACK=8'h41, RSP_NAK=8'h4E.
  - The FSM state enum.
- The same package is to be used by `memory_com`, so both ends stay consistent.
- One sub-module: `uart_tx_byte`.
  - Inputs: `start`, `data[7:0]`.
  - Outputs: `tx`, `done`.
  - Parameterized by CLKS_PER_BIT.
- The RX deserializer, FSM, and memory array stay in the top module.

## Test plan
- CLKS_PER_BIT=16, reset released: `tx`=1 and `busy`=0 for 200 cycles; `req_count`=0.
- Write `57 10 00 00 00 EF BE AD DE` → response `41`; `req_count`=1. Read `52 10 00 00 00` → `EF BE AD DE`; `req_count`=2.
- Read at 0x00001010 with DEPTH_LOG2=10 aliases word 4 → returns `EF BE AD DE`.
- Command `0x33` → response `4E`, one `frame_err` pulse, `req_count` unchanged. A following valid read still succeeds.
- Stop bit forced 0 on the second address byte → `frame_err` pulse, no response, FSM back in IDLE. The next full frame is answered correctly.
- With MEM_RESP_TIMEOUT_EN and TIMEOUT_CYCLES=500: send `52 10` then idle → `frame_err` pulse about 500 cycles after the last strobe, no `tx` activity. Assert `reset` low mid-response → `tx`=1 within the same cycle.

Source files
------------

// File: rtl/mem_link_pkg.sv
// mem_link_pkg: command/response codes and FSM states shared by both ends of the UART memory link
// Used by uart_mem_responder (this side) and memory_com (CPU side) so the framing never drifts apart.
package mem_link_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK   = 8'h41;
    localparam logic [7:0] RSP_NAK   = 8'h4E;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD_DECODE,
        ST_GET_ADDR,
        ST_GET_DATA,
        ST_MEM_ACCESS,
        ST_SEND
    } state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 serializer for one byte, chainable back-to-back
// Ports:
//   clk, reset  - clock, asynchronous active-low reset (tx forced high immediately)
//   start, data - load a byte; accepted when idle or in the cycle done is high
//   tx          - serial output, idle high
//   done        - high during the last cycle of the stop bit
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic          active_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    bit_q;
    logic [9:0]    shift_q;
    logic          tx_q;
    logic          load;

    assign done = active_q && bit_q == 4'd9 && cnt_q == LAST;
    // Accepting start on done lets the next start bit follow the stop bit with no idle gap.
    assign load = start && (!active_q || done);
    assign tx   = tx_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {active_q, cnt_q, bit_q, shift_q} <= '0;
            tx_q <= 1'b1;
        end else if (load) begin
            active_q <= 1'b1;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= {1'b1, data, 1'b0};
            tx_q     <= 1'b0;
        end else if (active_q) begin
            if (cnt_q == LAST) begin
                cnt_q    <= '0;
                bit_q    <= bit_q + 4'd1;
                shift_q  <= {1'b1, shift_q[9:1]};
                tx_q     <= bit_q == 4'd9 ? 1'b1 : shift_q[1];
                active_q <= bit_q != 4'd9;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_mem_responder.sv
// uart_mem_responder: UART-attached word memory answering read/write request frames
// Ports:
//   clk, reset - clock, asynchronous active-low reset
//   rx         - serial request input (8N1, asynchronous to clk)
//   tx         - serial response output, idle high
//   busy       - high from the cycle after the command byte until the last response stop bit ends
//   frame_err  - one-cycle pulse on bad stop bit, unknown command, or inter-byte timeout
//   req_count  - completed read/write requests, wrapping
// Build option: define MEM_RESP_TIMEOUT_EN to abort partial frames after TIMEOUT_CYCLES idle cycles.
module uart_mem_responder
    import mem_link_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 868,
    parameter int DEPTH_LOG2     = 10,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic        tx,
    output logic        busy,
    output logic        frame_err,
    output logic [15:0] req_count
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    // ---------------- RX deserializer ----------------
    logic          rx_meta_q, rx_sync_q, rx_prev_q, rx_act_q, rx_valid_q, rx_err_q;
    logic [CW-1:0] rx_cnt_q;
    logic [3:0]    rx_bit_q;
    logic [7:0]    rx_shift_q;

    // rx_bit_q: 0 = start-bit confirm, 1..8 = data, 9 = stop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {rx_meta_q, rx_sync_q, rx_prev_q} <= 3'b111;
            {rx_act_q, rx_valid_q, rx_err_q}  <= 3'b000;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            if (!rx_act_q) begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_act_q <= 1'b1;
                    rx_cnt_q <= '0;
                    rx_bit_q <= '0;
                end
            end else if (rx_cnt_q != (rx_bit_q == 4'd0 ? HALF : FULL)) begin
                rx_cnt_q <= rx_cnt_q + CW'(1);
            end else begin
                rx_cnt_q <= '0;
                rx_bit_q <= rx_bit_q + 4'd1;
                if (rx_bit_q == 4'd0) begin
                    // a low pulse shorter than half a bit is a glitch, not a start bit
                    rx_act_q <= !rx_sync_q;
                end else if (rx_bit_q == 4'd9) begin
                    rx_act_q   <= 1'b0;
                    rx_valid_q <= rx_sync_q;
                    rx_err_q   <= !rx_sync_q;
                end else begin
                    rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                end
            end
        end
    end

    // ---------------- request FSM and datapath ----------------
    state_e                  state_q, state_d;
    logic [7:0]              cmd_q;
    logic [1:0]              cnt_q, b_q;
    logic [31:0]             addr_q, data_q, rd_q;
    logic [15:0]             req_q;
    logic                    fe_q;
    logic [31:0]             mem [0:(1 << DEPTH_LOG2) - 1];
    logic [DEPTH_LOG2-1:0]   idx;
    logic                    cmd_ok, rx_open, more, abort, to_hit;
    logic                    tx_start, tx_done;
    logic [7:0]              tx_data;
    logic                    unused_addr;

    assign idx         = addr_q[DEPTH_LOG2+1:2];
    assign unused_addr = ^{addr_q[31:DEPTH_LOG2+2], addr_q[1:0]};
    assign cmd_ok      = cmd_q == CMD_WRITE || cmd_q == CMD_READ;
    // states in which incoming bytes are listened to; elsewhere they are dropped silently
    assign rx_open     = state_q == ST_IDLE || state_q == ST_GET_ADDR || state_q == ST_GET_DATA;
    assign abort       = rx_open && (rx_err_q || to_hit);
    assign more        = cmd_q == CMD_READ && b_q != 2'd0;

`ifdef MEM_RESP_TIMEOUT_EN
    logic [31:0] to_q;
    assign to_hit = (state_q == ST_GET_ADDR || state_q == ST_GET_DATA) && to_q == 32'(TIMEOUT_CYCLES);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            to_q <= '0;
        else
            to_q <= (state_q == ST_GET_ADDR || state_q == ST_GET_DATA) && !rx_valid_q && !to_hit ? to_q + 32'd1 : '0;
    end
`else
    logic unused_to;
    assign to_hit    = 1'b0;
    assign unused_to = ^32'(TIMEOUT_CYCLES);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:       state_d = rx_valid_q ? ST_CMD_DECODE : ST_IDLE;
            ST_CMD_DECODE: state_d = cmd_ok ? ST_GET_ADDR : ST_SEND;
            ST_GET_ADDR:   if (rx_valid_q && cnt_q == 2'd3) state_d = cmd_q == CMD_WRITE ? ST_GET_DATA : ST_MEM_ACCESS;
            ST_GET_DATA:   if (rx_valid_q && cnt_q == 2'd3) state_d = ST_MEM_ACCESS;
            ST_MEM_ACCESS: state_d = ST_SEND;
            ST_SEND:       if (tx_done && !more) state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
        if (abort)
            state_d = ST_IDLE;
    end

    // The first response byte launches from MEM_ACCESS (or CMD_DECODE for a NAK) so tx falls
    // two cycles after the final request strobe; later read bytes chain on tx_done.
    always_comb begin
        busy     = state_q != ST_IDLE;
        tx_start = state_q == ST_MEM_ACCESS || (state_q == ST_CMD_DECODE && !cmd_ok) || (state_q == ST_SEND && tx_done && more);
        tx_data  = state_q == ST_MEM_ACCESS ? (cmd_q == CMD_READ ? mem[idx][7:0] : RSP_ACK)
                 : state_q == ST_CMD_DECODE ? RSP_NAK
                 : rd_q[8*b_q +: 8];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_q  <= '0;
            cnt_q  <= '0;
            b_q    <= '0;
            addr_q <= '0;
            data_q <= '0;
            rd_q   <= '0;
            req_q  <= '0;
            fe_q   <= 1'b0;
        end else begin
            fe_q <= (state_q == ST_CMD_DECODE && !cmd_ok) || abort;
            if (state_q == ST_IDLE && rx_valid_q) begin
                cmd_q <= rx_shift_q;
                cnt_q <= '0;
            end
            if (state_q == ST_GET_ADDR && rx_valid_q) begin
                addr_q <= {rx_shift_q, addr_q[31:8]};
                cnt_q  <= cnt_q + 2'd1;
            end
            if (state_q == ST_GET_DATA && rx_valid_q) begin
                data_q <= {rx_shift_q, data_q[31:8]};
                cnt_q  <= cnt_q + 2'd1;
            end
            if (state_q == ST_MEM_ACCESS) begin
                rd_q  <= mem[idx];
                b_q   <= 2'd1;
                req_q <= req_q + 16'd1;
            end
            if (state_q == ST_SEND && tx_done)
                b_q <= b_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_MEM_ACCESS && cmd_q == CMD_WRITE)
            mem[idx] <= data_q;
    end

    assign frame_err = fe_q;
    assign req_count = req_q;

    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk   (clk),
        .reset (reset),
        .start (tx_start),
        .data  (tx_data),
        .tx    (tx),
        .done  (tx_done)
    );

endmodule

// File: tb/tb_uart_mem_responder.sv
// tb_uart_mem_responder: randomized self-checking bench with a word-level memory model
module tb_uart_mem_responder;

    localparam int CPB = 16;
    localparam int DL  = 10;
    localparam int TO  = 500;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx = 1'b1;
    logic        tx, busy, frame_err;
    logic [15:0] req_count;

    uart_mem_responder #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(DL), .TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .tx        (tx),
        .busy      (busy),
        .frame_err (frame_err),
        .req_count (req_count)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0, fe_cnt = 0, model_cnt = 0;
    logic [31:0] model_mem [int];
    logic [7:0]  req_q[$], exp_q[$], got_q[$];
    logic        stop_q[$];
    int          start_q[$];
    logic        mon_p = 1'b1;
    logic [7:0]  mon_b;
    int          mon_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % (32'd1 << DL));
    endfunction

    always @(posedge clk) cyc++;
    always @(negedge clk) if (frame_err === 1'b1) fe_cnt++;

    // per-cycle comparison against the model whenever the responder is idle
    always @(negedge clk) begin
        if (reset && !busy) begin
            check("idle_tx", {31'd0, tx}, 32'd1);
            check("req_count", {16'd0, req_count}, 32'(model_cnt));
        end
    end

    // tx decoder: records each byte, its stop bit and the cycle its start bit began
    initial begin
        forever begin
            @(negedge clk);
            if (reset && mon_p && !tx) begin
                mon_t = cyc;
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    mon_b = {tx, mon_b[7:1]};
                end
                repeat (CPB) @(negedge clk);
                got_q.push_back(mon_b);
                stop_q.push_back(tx);
                start_q.push_back(mon_t);
            end
            mon_p = tx;
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input bit good);
        logic [9:0] f;
        f = {good, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rx = f[i];
            repeat (CPB - 1) @(negedge clk);
        end
        @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic push_req(input logic [31:0] w);
        for (int i = 0; i < 4; i++) req_q.push_back(w[8*i +: 8]);
    endtask

    task automatic push_exp(input logic [31:0] w);
        for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic run(input string name, input int bad_idx, input int err_exp, input bit valid);
        int fe0;
        fe0 = fe_cnt;
        got_q.delete();
        stop_q.delete();
        start_q.delete();
        foreach (req_q[i]) begin
            send_byte(req_q[i], i != bad_idx);
            if (i == bad_idx) break;
            if (i == 0) check({name, "_busy_rise"}, {31'd0, busy}, 32'd1);
        end
        if (valid) model_cnt++;
        wait_idle(name);
        repeat (4) @(negedge clk);
        check({name, "_nrsp"}, 32'(got_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i < got_q.size()) begin
                check({name, "_byte"}, {24'd0, got_q[i]}, {24'd0, exp_q[i]});
                check({name, "_stop"}, {31'd0, stop_q[i]}, 32'd1);
            end
        end
        for (int k = 1; k < start_q.size(); k++)
            check({name, "_gap"}, 32'(start_q[k] - start_q[k-1]), 32'(10 * CPB));
        check({name, "_ferr"}, 32'(fe_cnt - fe0), 32'(err_exp));
    endtask

    logic [31:0] addr, data;
    logic [31:0] known[$];
    logic [7:0]  c;
    int          kind, fe0, t0, n;

    initial begin
        repeat (5) @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_cnt", {16'd0, req_count}, 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            check("post_rst_busy", {31'd0, busy}, 32'd0);
            check("post_rst_tx", {31'd0, tx}, 32'd1);
        end

        req_q = '{8'h57, 8'h10, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        exp_q = '{8'h41};
        model_mem[4] = 32'hDEADBEEF;
        run("write1", -1, 0, 1);
        check("write1_cnt", {16'd0, req_count}, 32'd1);

        req_q = '{8'h52, 8'h10, 8'h00, 8'h00, 8'h00};
        exp_q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run("read1", -1, 0, 1);
        check("read1_cnt", {16'd0, req_count}, 32'd2);

        req_q = '{8'h52, 8'h10, 8'h10, 8'h00, 8'h00};
        run("alias", -1, 0, 1);

        req_q = '{8'h33};
        exp_q = '{8'h4E};
        run("nak", -1, 1, 0);
        check("nak_cnt", {16'd0, req_count}, 32'd3);

        req_q = '{8'h52, 8'h10, 8'h00, 8'h00, 8'h00};
        exp_q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run("after_nak", -1, 0, 1);

        exp_q.delete();
        run("badstop", 2, 1, 0);
        check("badstop_busy", {31'd0, busy}, 32'd0);
        exp_q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run("after_bad", -1, 0, 1);

        known.push_back(32'h10);
        for (int t = 0; t < 20; t++) begin
            kind = $urandom_range(0, 9);
            req_q.delete();
            exp_q.delete();
            if (kind == 0) begin
                do c = 8'($urandom); while (c == 8'h57 || c == 8'h52);
                req_q.push_back(c);
                exp_q.push_back(8'h4E);
                run("rnd_nak", -1, 1, 0);
            end else if (kind < 5) begin
                addr = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
                data = $urandom;
                req_q.push_back(8'h57);
                push_req(addr);
                push_req(data);
                exp_q.push_back(8'h41);
                model_mem[widx(addr)] = data;
                known.push_back(addr);
                run("rnd_wr", -1, 0, 1);
            end else begin
                addr = known[$urandom_range(0, known.size() - 1)];
                addr = addr + (32'($urandom_range(0, 1023)) << (DL + 2)) + 32'($urandom_range(0, 3));
                req_q.push_back(8'h52);
                push_req(addr);
                push_exp(model_mem[widx(addr)]);
                run("rnd_rd", -1, 0, 1);
            end
        end

`ifdef MEM_RESP_TIMEOUT_EN
        fe0 = fe_cnt;
        got_q.delete();
        send_byte(8'h52, 1'b1);
        send_byte(8'h10, 1'b1);
        t0 = cyc;
        n = 0;
        while (fe_cnt == fe0 && n < 800) begin
            @(negedge clk);
            n++;
        end
        check("to_pulse", 32'(fe_cnt - fe0), 32'd1);
        check("to_latency_ok", {31'd0, (cyc - t0) >= 450 && (cyc - t0) <= 560}, 32'd1);
        repeat (4) @(negedge clk);
        check("to_busy", {31'd0, busy}, 32'd0);
        check("to_no_tx", 32'(got_q.size()), 32'd0);
`else
        fe0 = fe_cnt;
        got_q.delete();
        send_byte(8'h52, 1'b1);
        send_byte(8'h10, 1'b1);
        repeat (1000) @(negedge clk);
        check("wait_busy", {31'd0, busy}, 32'd1);
        check("wait_ferr", 32'(fe_cnt - fe0), 32'd0);
        check("wait_no_tx", 32'(got_q.size()), 32'd0);
        req_q = '{8'h00, 8'h00, 8'h00};
        exp_q.delete();
        push_exp(model_mem[4]);
        run("wait_done", -1, 0, 1);
`endif

        req_q = '{8'h52, 8'h10, 8'h00, 8'h00, 8'h00};
        foreach (req_q[i]) send_byte(req_q[i], 1'b1);
        n = 0;
        while (tx && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rstmid_tx_active", {31'd0, tx}, 32'd0);
        repeat (CPB * 13) @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_cnt = 0;
        #1;
        check("rstmid_tx", {31'd0, tx}, 32'd1);
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        check("rstmid_cnt", {16'd0, req_count}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (200) @(negedge clk);
        req_q = '{8'h52, 8'h10, 8'h00, 8'h00, 8'h00};
        exp_q.delete();
        push_exp(model_mem[4]);
        run("post_rst_read", -1, 0, 1);
        check("post_rst_cnt", {16'd0, req_count}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
